// File: rtl/mux_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH-bit output channel between
// two valid/ready requesters, with bounded bursts per grant for fairness.
module mux_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    beatCnt_q, beatCnt_d;
    logic             lastA_q, lastA_d;
    logic             outValid_q, outValid_d;
    logic [WIDTH-1:0] outData_q, outData_d;

    logic slotFree;
    logic grantA;
    logic grantValid;
    logic otherValid;
    logic accept;

    assign slotFree   = !outValid_q || out_ready;
    assign grantA     = (state_q == GNT_A);
    assign a_ready    = (state_q == GNT_A) && slotFree;
    assign b_ready    = (state_q == GNT_B) && slotFree;
    assign accept     = (a_valid && a_ready) || (b_valid && b_ready);
    assign grantValid = grantA ? a_valid : b_valid;
    assign otherValid = grantA ? b_valid : a_valid;

    assign sel       = grantA;
    assign busy      = (state_q != IDLE);
    assign out_valid = outValid_q;
    assign out_data  = outData_q;

    always_comb begin
        state_d    = state_q;
        beatCnt_d  = beatCnt_q;
        lastA_d    = lastA_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;

        if (accept) begin
            outValid_d = 1'b1;
            outData_d  = grantA ? a_data : b_data;
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // On a tie, the requester that was not served last wins.
                if (a_valid && (!b_valid || !lastA_q)) begin
                    state_d   = GNT_A;
                    beatCnt_d = '0;
                    lastA_d   = 1'b1;
                end else if (b_valid) begin
                    state_d   = GNT_B;
                    beatCnt_d = '0;
                    lastA_d   = 1'b0;
                end
            end
            GNT_A, GNT_B: begin
                // A stalled beat (valid but no free slot) leaves the budget untouched.
                if (!grantValid || (accept && beatCnt_q == LAST_BEAT)) begin
                    if (otherValid) begin
                        state_d   = grantA ? GNT_B : GNT_A;
                        beatCnt_d = '0;
                        lastA_d   = !grantA;
                    end else if (!grantValid) begin
                        state_d   = IDLE;
                    end else begin
                        beatCnt_d = '0;
                    end
                end else if (accept) begin
                    beatCnt_d = beatCnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beatCnt_q  <= '0;
            lastA_q    <= 1'b0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
        end else begin
            state_q    <= state_d;
            beatCnt_q  <= beatCnt_d;
            lastA_q    <= lastA_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: directed producer streams, expected beats
// queued in hand-computed order, monitor pops on every output handshake.
module tb_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, b_valid, a_ready, b_ready;
    logic [7:0] a_data, b_data, out_data;
    logic       out_valid, out_ready, sel, busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] aSrc[$];
    logic [7:0] bSrc[$];
    logic [7:0] expQ[$];

    mux_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .sel(sel), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Present the head of each producer stream; valid drops when a stream is empty.
    task automatic applyStimulus();
        a_valid = (aSrc.size() > 0);
        a_data  = (aSrc.size() > 0) ? aSrc[0] : 8'h00;
        b_valid = (bSrc.size() > 0);
        b_data  = (bSrc.size() > 0) ? bSrc[0] : 8'h00;
    endtask

    task automatic stepCycle();
        logic aAcc, bAcc;
        @(negedge clk);
        aAcc = rst_n && a_valid && a_ready;
        bAcc = rst_n && b_valid && b_ready;
        @(posedge clk);
        #1;
        if (aAcc) void'(aSrc.pop_front());
        if (bAcc) void'(bSrc.pop_front());
        applyStimulus();
    endtask

    task automatic resetDut();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        aSrc.delete();
        bSrc.delete();
        applyStimulus();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checkOutput("ready_exclusive", {7'd0, a_ready && b_ready}, 8'd0);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL scoreboard: got unexpected beat %h expected none at %0t", out_data, $time);
                end else begin
                    checkOutput("scoreboard", out_data, expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        // Reset holds everything quiet even with both requesters asserting.
        rst_n = 1'b0; out_ready = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hAA; b_data = 8'hBB;
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("rst_out_valid", {7'd0, out_valid}, 8'd0);
            checkOutput("rst_a_ready", {7'd0, a_ready}, 8'd0);
            checkOutput("rst_b_ready", {7'd0, b_ready}, 8'd0);
            checkOutput("rst_sel", {7'd0, sel}, 8'd0);
            checkOutput("rst_busy", {7'd0, busy}, 8'd0);
        end

        // Single requester streaming back to back.
        resetDut();
        aSrc = '{8'h11, 8'h12, 8'h13};
        expQ.push_back(8'h11); expQ.push_back(8'h12); expQ.push_back(8'h13);
        applyStimulus();
        stepCycle();
        checkOutput("single_sel", {7'd0, sel}, 8'd1);
        checkOutput("single_busy", {7'd0, busy}, 8'd1);
        checkOutput("single_valid0", {7'd0, out_valid}, 8'd0);
        stepCycle(); checkOutput("single_d11", out_data, 8'h11);
        stepCycle(); checkOutput("single_d12", out_data, 8'h12);
        stepCycle(); checkOutput("single_d13", out_data, 8'h13);
        stepCycle();
        checkOutput("single_idle", {7'd0, busy}, 8'd0);
        checkOutput("single_drain", {7'd0, out_valid}, 8'd0);

        // Contention: bursts of four alternate with no bubble at the switch.
        resetDut();
        for (int i = 0; i < 12; i++) aSrc.push_back(8'hA0 + 8'(i));
        for (int i = 0; i < 8; i++) bSrc.push_back(8'hB0 + 8'(i));
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 4; i++) expQ.push_back(8'hA0 + 8'(g * 4 + i));
            for (int i = 0; i < 4; i++) expQ.push_back(8'hB0 + 8'(g * 4 + i));
        end
        for (int i = 8; i < 12; i++) expQ.push_back(8'hA0 + 8'(i));
        applyStimulus();
        stepCycle();
        checkOutput("cont_first_a", {7'd0, sel}, 8'd1);
        for (int k = 2; k <= 21; k++) begin
            stepCycle();
            checkOutput("cont_valid", {7'd0, out_valid}, 8'd1);
            checkOutput("cont_sel", {7'd0, sel},
                        {7'd0, (k >= 17) || (((k - 1) / 4) % 2 == 0)});
        end
        stepCycle();
        checkOutput("cont_idle", {7'd0, busy}, 8'd0);

        // Backpressure must not consume burst budget.
        resetDut();
        aSrc = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        bSrc = '{8'hB1};
        expQ.push_back(8'h41); expQ.push_back(8'h42); expQ.push_back(8'h43);
        expQ.push_back(8'h44); expQ.push_back(8'hB1); expQ.push_back(8'h45);
        applyStimulus();
        stepCycle();
        stepCycle();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("bp_valid", {7'd0, out_valid}, 8'd1);
            checkOutput("bp_hold", out_data, 8'h41);
            checkOutput("bp_a_ready", {7'd0, a_ready}, 8'd0);
            checkOutput("bp_sel", {7'd0, sel}, 8'd1);
        end
        out_ready = 1'b1;
        stepCycle(); checkOutput("bp_d42", out_data, 8'h42);
        stepCycle(); checkOutput("bp_d43", out_data, 8'h43);
        stepCycle();
        checkOutput("bp_d44", out_data, 8'h44);
        checkOutput("bp_rotate_b", {7'd0, sel}, 8'd0);
        stepCycle(); checkOutput("bp_dB1", out_data, 8'hB1);
        stepCycle(); checkOutput("bp_back_a", {7'd0, sel}, 8'd1);
        stepCycle(); checkOutput("bp_d45", out_data, 8'h45);
        stepCycle();

        // Early drop of A hands the channel to B on the next edge.
        resetDut();
        aSrc = '{8'h51, 8'h52};
        bSrc = '{8'hB0};
        expQ.push_back(8'h51); expQ.push_back(8'h52); expQ.push_back(8'hB0);
        applyStimulus();
        stepCycle();
        stepCycle();
        stepCycle(); checkOutput("drop_d52", out_data, 8'h52);
        stepCycle();
        checkOutput("drop_sel", {7'd0, sel}, 8'd0);
        checkOutput("drop_b_ready", {7'd0, b_ready}, 8'd1);
        checkOutput("drop_busy", {7'd0, busy}, 8'd1);
        checkOutput("drop_gap", {7'd0, out_valid}, 8'd0);
        stepCycle();
        checkOutput("drop_valid", {7'd0, out_valid}, 8'd1);
        checkOutput("drop_dB0", out_data, 8'hB0);
        stepCycle();

        // Reset mid-burst discards the held beat.
        resetDut();
        aSrc = '{8'h61, 8'h62, 8'h63};
        applyStimulus();
        stepCycle();
        stepCycle();
        out_ready = 1'b0;
        checkOutput("mid_held", {7'd0, out_valid}, 8'd1);
        rst_n = 1'b0;
        stepCycle();
        checkOutput("mid_rst_valid", {7'd0, out_valid}, 8'd0);
        checkOutput("mid_rst_busy", {7'd0, busy}, 8'd0);
        checkOutput("mid_rst_sel", {7'd0, sel}, 8'd0);
        aSrc.delete();
        bSrc = '{8'hB6};
        expQ.push_back(8'hB6);
        out_ready = 1'b1;
        rst_n = 1'b1;
        applyStimulus();
        stepCycle();
        checkOutput("mid_b_sel", {7'd0, sel}, 8'd0);
        checkOutput("mid_b_busy", {7'd0, busy}, 8'd1);
        checkOutput("mid_b_ready", {7'd0, b_ready}, 8'd1);
        checkOutput("mid_a_ready", {7'd0, a_ready}, 8'd0);
        stepCycle(); checkOutput("mid_dB6", out_data, 8'hB6);
        repeat (3) stepCycle();

        checkOutput("scoreboard_empty", 8'(expQ.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
